// File: rtl/ddr3_pkg.sv
// Shared definitions for the DDR3 line fetcher: FSM state encoding and the
// helpers that derive the burst geometry from the line and beat widths.
package ddr3_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_COLLECT = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // Number of controller words that make up one cache line.
    function automatic int unsigned calc_beats(input int unsigned lines_w,
                                               input int unsigned mem_data_w);
        return lines_w / mem_data_w;
    endfunction

    // Width of a beat index (log2 of the beat count, which is a power of 2).
    function automatic int unsigned calc_beat_w(input int unsigned beats);
        return $clog2(beats);
    endfunction

endpackage

// File: rtl/line_assembler.sv
// Line assembler: counts incoming read beats and drops each one into its
// slot of the line register. The line register is also the fetcher's output,
// so it keeps the last completed line until new beats overwrite it.
module line_assembler
    import ddr3_pkg::*;
#(
    parameter int LINES_W    = 128,
    parameter int MEM_DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [MEM_DATA_W-1:0] wr_data,
    output logic                  last_beat,
    output logic [LINES_W-1:0]    line
);

    localparam int BEATS  = calc_beats(LINES_W, MEM_DATA_W);
    localparam int BEAT_W = calc_beat_w(BEATS);

    logic [BEAT_W-1:0] beat_cnt;

    // The beat being written now is the one that completes the line.
    assign last_beat = wr_en && (beat_cnt == BEAT_W'(BEATS - 1));

    // Slot writes and beat counting; the counter wraps naturally at BEATS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            line     <= '0;
        end else if (clear) begin
            beat_cnt <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < BEATS; i++) begin
                if (beat_cnt == BEAT_W'(i)) begin
                    line[i*MEM_DATA_W +: MEM_DATA_W] <= wr_data;
                end
            end
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ddr3_line_fetcher.sv
// DDR3 line fetcher: turns one cache line-miss request into a single Avalon-MM
// burst read, assembles the returned beats into a line and signals completion
// with a one-cycle ext_rq_finished pulse. One request outstanding at a time.
// Optional build macro LINE_FETCH_TIMEOUT_EN adds a watchdog that aborts a
// stalled fetch after TIMEOUT_CYC busy cycles and flags it on ext_err.
module ddr3_line_fetcher
    import ddr3_pkg::*;
#(
    parameter int LINES_W     = 128,
    parameter int MEM_DATA_W  = 32,
    parameter int EXT_ADDR_W  = 26,
    parameter int MEM_ADDR_W  = 28,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          ext_read_rq,
    input  logic [EXT_ADDR_W-1:0]                         ext_address,
    output logic                                          ext_rq_finished,
    output logic [LINES_W-1:0]                            ext_data,
    output logic                                          ext_err,
    output logic                                          avl_read_req,
    output logic [MEM_ADDR_W-1:0]                         avl_addr,
    output logic [calc_beat_w(calc_beats(LINES_W, MEM_DATA_W)):0] avl_burstcount,
    input  logic                                          avl_ready,
    input  logic                                          avl_rdata_valid,
    input  logic [MEM_DATA_W-1:0]                         avl_rdata,
    output logic                                          busy
);

    localparam int BEATS  = calc_beats(LINES_W, MEM_DATA_W);
    localparam int BEAT_W = calc_beat_w(BEATS);

    if ((LINES_W % MEM_DATA_W) != 0 || BEATS < 2 || (BEATS & (BEATS - 1)) != 0 ||
        MEM_ADDR_W < EXT_ADDR_W + BEAT_W || TIMEOUT_CYC < 1) begin : g_cfg_check
        $error("ddr3_line_fetcher: inconsistent parameter set");
    end

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [EXT_ADDR_W-1:0] addr_q;
    logic                  asm_clear;
    logic                  asm_wr_en;
    logic                  asm_last;
    logic                  tmo_hit;

    assign asm_clear = (state == ST_IDLE) && ext_read_rq;
    assign asm_wr_en = (state == ST_COLLECT) && avl_rdata_valid;

    assign busy            = (state != ST_IDLE);
    assign avl_read_req    = (state == ST_ISSUE);
    assign ext_rq_finished = (state == ST_DONE);
    assign avl_addr        = MEM_ADDR_W'({addr_q, {BEAT_W{1'b0}}});
    assign avl_burstcount  = (BEAT_W + 1)'(BEATS);

    line_assembler #(
        .LINES_W    (LINES_W),
        .MEM_DATA_W (MEM_DATA_W)
    ) u_line_assembler (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (asm_clear),
        .wr_en     (asm_wr_en),
        .wr_data   (avl_rdata),
        .last_beat (asm_last),
        .line      (ext_data)
    );

`ifdef LINE_FETCH_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;

    assign tmo_hit = (state == ST_ISSUE || state == ST_COLLECT) &&
                     (tmo_cnt >= TMO_W'(TIMEOUT_CYC - 1));
    assign ext_err = (state == ST_DONE) && err_q;

    // Watchdog counts busy cycles of the current fetch, restarting on each new request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (asm_clear) begin
            tmo_cnt <= '0;
        end else if (state == ST_ISSUE || state == ST_COLLECT) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Remember whether DONE was reached by the watchdog rather than by the final beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state == ST_ISSUE || state == ST_COLLECT) &&
                     (state_nxt == ST_DONE) && !asm_last;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign ext_err = 1'b0;
`endif

    // Next-state logic; a real completion wins over a simultaneous watchdog expiry.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (ext_read_rq) state_nxt = ST_ISSUE;
            ST_ISSUE:   if (avl_ready) state_nxt = ST_COLLECT;
                        else if (tmo_hit) state_nxt = ST_DONE;
            ST_COLLECT: if (asm_last || tmo_hit) state_nxt = ST_DONE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the line address when a request is accepted; later changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else if (asm_clear) begin
            addr_q <= ext_address;
        end
    end

endmodule

// File: tb/tb_ddr3_line_fetcher.sv
// Testbench for ddr3_line_fetcher (default build). A driver issues line
// requests and plays the DDR3 controller; expected commands and lines are
// queued when each request starts, and a monitor pops and compares them
// whenever the DUT presents a command or a completed line.
module tb_ddr3_line_fetcher;

    localparam int LINES_W    = 128;
    localparam int MEM_DATA_W = 32;
    localparam int EXT_ADDR_W = 26;
    localparam int MEM_ADDR_W = 28;
    localparam int BEATS      = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  ext_read_rq = 1'b0;
    logic [EXT_ADDR_W-1:0] ext_address = '0;
    logic                  ext_rq_finished;
    logic [LINES_W-1:0]    ext_data;
    logic                  ext_err;
    logic                  avl_read_req;
    logic [MEM_ADDR_W-1:0] avl_addr;
    logic [2:0]            avl_burstcount;
    logic                  avl_ready = 1'b0;
    logic                  avl_rdata_valid = 1'b0;
    logic [MEM_DATA_W-1:0] avl_rdata = '0;
    logic                  busy;

    ddr3_line_fetcher #(
        .LINES_W     (LINES_W),
        .MEM_DATA_W  (MEM_DATA_W),
        .EXT_ADDR_W  (EXT_ADDR_W),
        .MEM_ADDR_W  (MEM_ADDR_W),
        .TIMEOUT_CYC (1024)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ext_read_rq     (ext_read_rq),
        .ext_address     (ext_address),
        .ext_rq_finished (ext_rq_finished),
        .ext_data        (ext_data),
        .ext_err         (ext_err),
        .avl_read_req    (avl_read_req),
        .avl_addr        (avl_addr),
        .avl_burstcount  (avl_burstcount),
        .avl_ready       (avl_ready),
        .avl_rdata_valid (avl_rdata_valid),
        .avl_rdata       (avl_rdata),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    int unsigned last_fin_cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    logic [MEM_ADDR_W-1:0] exp_cmd_q[$];
    logic [LINES_W-1:0]    exp_line_q[$];
    logic [LINES_W-1:0]    last_line = '0;
    logic [MEM_ADDR_W-1:0] mon_cmd;
    logic [LINES_W-1:0]    mon_line;

    // Free-running cycle counter used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [LINES_W-1:0] act,
                               input logic [LINES_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever a command is accepted or a line completes.
    always @(negedge clk) begin
        if (rst_n) begin
            if (avl_read_req && avl_ready) begin
                if (exp_cmd_q.size() == 0) begin
                    checkOutput("unexpected_cmd", avl_read_req, 0);
                end else begin
                    mon_cmd = exp_cmd_q.pop_front();
                    checkOutput("avl_addr", avl_addr, mon_cmd);
                    checkOutput("avl_burstcount", avl_burstcount, BEATS);
                end
            end
            if (ext_rq_finished) begin
                if (exp_line_q.size() == 0) begin
                    checkOutput("unexpected_finished", ext_rq_finished, 0);
                end else begin
                    mon_line = exp_line_q.pop_front();
                    checkOutput("ext_data", ext_data, mon_line);
                    checkOutput("ext_err", ext_err, 0);
                end
            end
        end
    end

    // One fetch: called #1 after a posedge, returns #1 after the posedge that
    // follows the finished pulse (or after reset release when aborted).
    task automatic applyStimulus(input logic [EXT_ADDR_W-1:0] addr,
                                 input logic [MEM_DATA_W-1:0] beat[BEATS],
                                 input int ready_delay, input int gap,
                                 input int abort_after, input bit expect_b2b);
        logic [LINES_W-1:0]    exp_line;
        logic [MEM_ADDR_W-1:0] exp_cmd;
        exp_line = '0;
        for (int i = 0; i < BEATS; i++)
            exp_line = exp_line | (LINES_W'(beat[i]) << (MEM_DATA_W * i));
        exp_cmd = MEM_ADDR_W'(int'(addr) * BEATS);
        exp_cmd_q.push_back(exp_cmd);
        if (abort_after >= BEATS) exp_line_q.push_back(exp_line);

        ext_read_rq = 1'b1;
        ext_address = addr;
        avl_ready   = 1'b0;
        @(negedge clk);
        checkOutput("req_cycle0_idle", avl_read_req, 0);
        for (int k = 0; k <= ready_delay; k++) begin
            @(posedge clk); #1;
            avl_ready = (k == ready_delay);
            @(negedge clk);
            checkOutput("avl_read_req_held", avl_read_req, 1);
            checkOutput("avl_addr_held", avl_addr, exp_cmd);
            if (k == 0 && expect_b2b) checkOutput("b2b_issue_gap", cyc - last_fin_cyc, 2);
            if (k == 0) ext_address = EXT_ADDR_W'($urandom);
        end
        @(posedge clk); #1;
        avl_ready = 1'b0;
        @(negedge clk);
        checkOutput("single_cmd", avl_read_req, 0);

        for (int b = 0; b < BEATS; b++) begin
            if (b == abort_after) begin
                @(posedge clk); #1;
                avl_rdata_valid = 1'b0;
                rst_n = 1'b0;
                ext_read_rq = 1'b0;
                @(negedge clk);
                checkOutput("rst_busy", busy, 0);
                checkOutput("rst_ext_data", ext_data, 0);
                checkOutput("rst_finished", ext_rq_finished, 0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                last_line = '0;
                return;
            end
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                avl_rdata_valid = 1'b0;
                avl_rdata = $urandom;
            end
            @(posedge clk); #1;
            avl_rdata_valid = 1'b1;
            avl_rdata = beat[b];
        end
        @(posedge clk); #1;
        avl_rdata_valid = 1'b0;
        @(negedge clk);
        checkOutput("finish_latency", ext_rq_finished, 1);
        last_fin_cyc = cyc;
        last_line = exp_line;
        @(posedge clk); #1;
        ext_read_rq = 1'b0;
    endtask

    // Main stimulus sequence: directed cases first, then randomized fetches.
    initial begin
        logic [MEM_DATA_W-1:0] bt[BEATS];
        int idle;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_avl_read_req", avl_read_req, 0);
        checkOutput("reset_finished", ext_rq_finished, 0);
        checkOutput("reset_ext_err", ext_err, 0);
        checkOutput("reset_ext_data", ext_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        bt = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        applyStimulus(26'h000123, bt, 0, 0, BEATS, 1'b0);

        avl_rdata_valid = 1'b1;
        avl_rdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        avl_rdata_valid = 1'b0;
        @(negedge clk);
        checkOutput("idle_stray_beat", ext_data, last_line);
        checkOutput("idle_not_busy", busy, 0);
        @(posedge clk); #1;

        for (int i = 0; i < BEATS; i++) bt[i] = $urandom;
        applyStimulus(EXT_ADDR_W'($urandom), bt, 5, 0, BEATS, 1'b0);
        @(posedge clk); #1;

        applyStimulus(26'h000123, '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444},
                      0, 3, BEATS, 1'b0);
        @(posedge clk); #1;

        for (int i = 0; i < BEATS; i++) bt[i] = $urandom;
        applyStimulus(EXT_ADDR_W'($urandom), bt, 1, 1, BEATS, 1'b0);
        for (int i = 0; i < BEATS; i++) bt[i] = $urandom;
        applyStimulus(EXT_ADDR_W'($urandom), bt, 0, 0, BEATS, 1'b1);
        @(posedge clk); #1;

        for (int i = 0; i < BEATS; i++) bt[i] = $urandom;
        applyStimulus(EXT_ADDR_W'($urandom), bt, 0, 0, 2, 1'b0);
        @(negedge clk);
        checkOutput("post_reset_idle", busy, 0);
        @(posedge clk); #1;

        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < BEATS; i++) bt[i] = $urandom;
            idle = $urandom_range(0, 2);
            for (int w = 0; w < idle; w++) begin
                @(posedge clk); #1;
            end
            applyStimulus(EXT_ADDR_W'($urandom), bt, $urandom_range(0, 4),
                          $urandom_range(0, 3), BEATS, (idle == 0) && (n > 0));
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("final_idle", busy, 0);
        checkOutput("cmd_queue_drained", exp_cmd_q.size(), 0);
        checkOutput("line_queue_drained", exp_line_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound so a stuck DUT cannot hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
